// File: rtl/rf_txn_ctrl_if.sv
// Host command / read-result / serializer signal bundle for rf_txn_ctrl.
// slave is the controller side, master is the host+serializer side.
interface rf_txn_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       err_timeout;
  logic       rf_c_en;
  logic [1:0] rf_mode;
  logic [9:0] rf_addr;
  logic [7:0] rf_data;
  logic       rf_ready;
  logic       rf_cs;
  logic       rf_dout;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_addr, cmd_data, rf_ready, rf_cs, rf_dout,
    output cmd_ready, rd_valid, rd_data, busy, err_timeout,
           rf_c_en, rf_mode, rf_addr, rf_data
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_addr, cmd_data, rf_ready, rf_cs, rf_dout,
    input  cmd_ready, rd_valid, rd_data, busy, err_timeout,
           rf_c_en, rf_mode, rf_addr, rf_data
  );
endinterface

// File: rtl/rf_txn_ctrl.sv
// Radio SPI transaction controller: command FIFO, issue/track FSM keyed on chip-select,
// and serial read-back deserializer with a one-cycle result strobe.
module rf_txn_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  rf_txn_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 20;
  localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE, DONE} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [7:0]      shift_q, shift_d;
  logic            rf_c_en_q, rf_c_en_d;
  logic [1:0]      rf_mode_q, rf_mode_d;
  logic [9:0]      rf_addr_q, rf_addr_d;
  logic [7:0]      rf_data_q, rf_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            err_q, err_d;

  logic            fifo_empty, fifo_full, push, pop;
  logic [EW-1:0]   head;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = bus.cmd_valid & ~fifo_full;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // FIFO storage needs no reset; occupancy is defined by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.cmd_mode, bus.cmd_addr, bus.cmd_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tmo_q      <= '0;
      shift_q    <= '0;
      rf_c_en_q  <= 1'b0;
      rf_mode_q  <= '0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tmo_q      <= tmo_d;
      shift_q    <= shift_d;
      rf_c_en_q  <= rf_c_en_d;
      rf_mode_q  <= rf_mode_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    shift_d    = shift_q;
    rf_c_en_d  = rf_c_en_q;
    rf_mode_d  = rf_mode_q;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && bus.rf_ready) begin
          pop                               = 1'b1;
          {rf_mode_d, rf_addr_d, rf_data_d} = head;
          rf_c_en_d                         = 1'b1;
          tmo_d                             = '0;
          state_d                           = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.rf_cs) begin
          rf_c_en_d = 1'b0;
          shift_d   = '0;
          state_d   = ACTIVE;
        end else begin
          tmo_d = tmo_q + CW'(1);
          if (tmo_d == CW'(START_TIMEOUT)) begin
            rf_c_en_d = 1'b0;
            err_d     = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      ACTIVE: begin
        // Shifting every cs-low cycle leaves the last 8 bits, whatever the frame length.
        if (!bus.rf_cs) begin
          shift_d = {shift_q[6:0], bus.rf_dout};
        end else if (!rf_mode_q[0]) begin
          rd_valid_d = 1'b1;
          rd_data_d  = shift_q;
          state_d    = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  assign bus.cmd_ready   = ~fifo_full;
  assign bus.busy        = (state_q != IDLE) | ~fifo_empty;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.err_timeout = err_q;
  assign bus.rf_c_en     = rf_c_en_q;
  assign bus.rf_mode     = rf_mode_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_data     = rf_data_q;

endmodule
